// File: rtl/barret_inv_1907.sv
// barret_inv_1907
//   Sequential modular inverse for the prime Q = 1907. Computes a^(Q-2) mod Q
//   with MSB-first square-and-multiply, one Barrett-reduced modular multiply
//   per clock through a single shared multiplier. One operation in flight.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   din_a is valid
//   in_ready   block can accept an operand (high only in IDLE)
//   din_a      operand, any K-bit value
//   out_valid  dout_r / dout_err valid, held until out_ready
//   out_ready  consumer accepts the result
//   dout_r     a^-1 mod Q, or 0 when a == 0 mod Q
//   dout_err   operand had no inverse (a == 0 mod Q)
module barret_inv_1907 #(
  parameter int Q   = 1907,
  parameter int K   = 11,
  parameter int MU  = 2199,
  parameter int EXP = 1905
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [K-1:0] din_a,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [K-1:0] dout_r,
  output logic         dout_err
);

  localparam int IDX_W = $clog2(K);

  localparam logic [K-1:0]     Q_K   = K'(Q);
  localparam logic [2*K:0]     Q_W   = (2*K+1)'(Q);
  localparam logic [2*K+1:0]   MU_W  = (2*K+2)'(MU);
  localparam logic [K-1:0]     EXP_W = K'(EXP);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(K-1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQR  = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_reg;
  logic [K-1:0]     acc_reg;
  logic [K-1:0]     base_reg;
  logic [IDX_W-1:0] idx_reg;

  // Barrett reduction of x < Q^2. q1*MU can reach ~2^23 for x near Q^2,
  // so that product is kept two bits wider than x to avoid any truncation
  // before the shift. The quotient estimate undershoots by at most 2, hence
  // two conditional corrections.
  function automatic logic [K-1:0] red(input logic [2*K-1:0] x);
    logic [K:0]     q1;
    logic [2*K+1:0] qm;
    logic [K:0]     t;
    logic [2*K:0]   r;
    q1 = x[2*K-1:K-1];
    qm = {{(K+1){1'b0}}, q1} * MU_W;
    t  = qm[2*K+1:K+1];
    r  = {1'b0, x} - ({{K{1'b0}}, t} * Q_W);
    if (r >= Q_W) r = r - Q_W;
    if (r >= Q_W) r = r - Q_W;
    return r[K-1:0];
  endfunction

  // Shared multiplier: squaring in SQR, multiply by base in MUL.
  logic [K-1:0]   mul_b;
  logic [2*K-1:0] prod;
  logic [K-1:0]   red_out;

  always_comb begin
    mul_b   = (state_reg == MUL) ? base_reg : acc_reg;
    prod    = {{K{1'b0}}, acc_reg} * {{K{1'b0}}, mul_b};
    red_out = red(prod);
  end

  assign in_ready = (state_reg == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      base_reg  <= '0;
      idx_reg   <= IDX_TOP;
      out_valid <= 1'b0;
      dout_r    <= '0;
      dout_err  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            // 2^K < 2Q, so one subtract fully reduces the operand.
            base_reg  <= (din_a >= Q_K) ? (din_a - Q_K) : din_a;
            acc_reg   <= K'(1);
            idx_reg   <= IDX_TOP;
            state_reg <= SQR;
          end
        end

        SQR: begin
          acc_reg <= red_out;
          if (EXP_W[idx_reg]) begin
            state_reg <= MUL;
          end else if (idx_reg == '0) begin
            state_reg <= DONE;
            out_valid <= 1'b1;
            dout_r    <= red_out;
            dout_err  <= (base_reg == '0);
          end else begin
            idx_reg <= idx_reg - IDX_ONE;
          end
        end

        MUL: begin
          acc_reg <= red_out;
          if (idx_reg == '0) begin
            state_reg <= DONE;
            out_valid <= 1'b1;
            dout_r    <= red_out;
            dout_err  <= (base_reg == '0);
          end else begin
            idx_reg   <= idx_reg - IDX_ONE;
            state_reg <= SQR;
          end
        end

        DONE: begin
          // Result is held until accepted; the drain edge never accepts.
          if (out_ready) begin
            state_reg <= IDLE;
            out_valid <= 1'b0;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_barret_inv_1907.sv
module tb_barret_inv_1907;

  localparam int Q = 1907;
  localparam int K = 11;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [K-1:0] din_a;
  logic         out_valid;
  logic         out_ready;
  logic [K-1:0] dout_r;
  logic         dout_err;

  int tests = 0;
  int fails = 0;

  barret_inv_1907 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din_a     (din_a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout_r    (dout_r),
    .dout_err  (dout_err)
  );

  always #5 clk = ~clk;

  // Reference: extended Euclid over the integers.
  function automatic int inv_ref(input int a_in);
    int a, t, newt, r, newr, q, tmp;
    a = a_in % Q;
    if (a == 0) return 0;
    t = 0; newt = 1; r = Q; newr = a;
    while (newr != 0) begin
      q = r / newr;
      tmp = t - q * newt; t = newt; newt = tmp;
      tmp = r - q * newr; r = newr; newr = tmp;
    end
    if (t < 0) t += Q;
    return t;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge after the accept edge; counts edges until out_valid.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!out_valid) check("timeout_out_valid", 0, 1);
  endtask

  task automatic drain();
    check("drain_out_valid", int'(out_valid), 1);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("post_drain_out_valid", int'(out_valid), 0);
    check("post_drain_in_ready", int'(in_ready), 1);
  endtask

  task automatic run_op(input int a, input int stalls,
                        output int r, output int e, output int lat);
    int r0;
    @(negedge clk);
    check("pre_accept_in_ready", int'(in_ready), 1);
    in_valid = 1'b1;
    din_a    = K'(a);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("busy_in_ready", int'(in_ready), 0);
    wait_result(lat);
    r0 = int'(dout_r);
    for (int s = 0; s < stalls; s++) begin
      check("stall_out_valid", int'(out_valid), 1);
      check("stall_dout_r", int'(dout_r), r0);
      @(negedge clk);
    end
    r = int'(dout_r);
    e = int'(dout_err);
    drain();
  endtask

  int r, e, lat;
  int dir_a   [6] = '{2, 1, 3, 1906, 1909, 5};
  int dir_exp [6] = '{954, 1, 636, 1906, 954, 763};

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; din_a = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_dout_r", int'(dout_r), 0);
    check("rst_dout_err", int'(dout_err), 0);
    check("rst_in_ready", int'(in_ready), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed operands
    for (int i = 0; i < 6; i++) begin
      run_op(dir_a[i], 0, r, e, lat);
      check($sformatf("dir_r_a%0d", dir_a[i]), r, dir_exp[i]);
      check($sformatf("dir_err_a%0d", dir_a[i]), e, 0);
      check($sformatf("dir_lat_a%0d", dir_a[i]), lat, 18);
      $display("[TB] a=%0d r=%0d err=%0d lat=%0d", dir_a[i], r, e, lat);
    end

    // Zero-class operands
    run_op(0, 0, r, e, lat);
    check("zero_r", r, 0); check("zero_err", e, 1); check("zero_lat", lat, 18);
    $display("[TB] a=0 r=%0d err=%0d lat=%0d", r, e, lat);
    run_op(1907, 0, r, e, lat);
    check("q_r", r, 0); check("q_err", e, 1); check("q_lat", lat, 18);
    $display("[TB] a=1907 r=%0d err=%0d lat=%0d", r, e, lat);

    // Backpressure with a second request held throughout
    @(negedge clk);
    in_valid = 1'b1; din_a = K'(2);
    @(posedge clk);
    @(negedge clk);
    din_a = K'(3);
    wait_result(lat);
    check("bp_lat", lat, 18);
    for (int s = 0; s < 5; s++) begin
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_dout_r", int'(dout_r), 954);
      check("bp_in_ready", int'(in_ready), 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_drain_out_valid", int'(out_valid), 0);
    check("bp_drain_in_ready", int'(in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_second_accepted", int'(in_ready), 0);
    wait_result(lat);
    check("bp2_lat", lat, 18);
    check("bp2_r", int'(dout_r), 636);
    $display("[TB] backpressure second a=3 r=%0d lat=%0d", dout_r, lat);
    drain();

    // Asynchronous reset mid-operation
    @(negedge clk);
    in_valid = 1'b1; din_a = K'(7);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_dout_r", int'(dout_r), 0);
    check("midrst_dout_err", int'(dout_err), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(5, 0, r, e, lat);
    check("after_rst_r", r, 763);
    check("after_rst_prod", (5 * r) % Q, 1);
    $display("[TB] after reset a=5 r=%0d", r);

    // Exhaustive sweep with random stalls
    for (int a = 1; a < Q; a++) begin
      int st;
      st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_op(a, st, r, e, lat);
      check($sformatf("sweep_r_a%0d", a), r, inv_ref(a));
      check($sformatf("sweep_prod_a%0d", a), (a * r) % Q, 1);
      check($sformatf("sweep_err_a%0d", a), e, 0);
      check($sformatf("sweep_lat_a%0d", a), lat, 18);
      $display("[TB] sweep a=%0d r=%0d stalls=%0d", a, r, st);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
